// File: rtl/fw_sprite_pkg.sv
// Shared types and constants for the Fireboy sprite animation path.
//   sprite_sel_t : 4-bit code selecting the sprite ROM / palette pair
//   motion_t     : motion state of the character
//   WALK_FRAMES  : number of images in the walk cycle
//   next_walk_idx: walk-cycle index successor (1 -> 2 -> 3 -> 1)
package fw_sprite_pkg;

    typedef enum logic [3:0] {
        SPR_IDLE   = 4'd0,
        SPR_L1     = 4'd1,
        SPR_L2     = 4'd2,
        SPR_L3     = 4'd3,
        SPR_R1     = 4'd4,
        SPR_R2     = 4'd5,
        SPR_R3     = 4'd6,
        SPR_JUMP_L = 4'd7,
        SPR_JUMP_R = 4'd8
    } sprite_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_L = 2'd1,
        WALK_R = 2'd2,
        AIR    = 2'd3
    } motion_t;

    localparam logic [1:0] WALK_FRAMES = 2'd3;

    // Walk index is 1-based, so index 0 never occurs.
    function automatic logic [1:0] next_walk_idx(input logic [1:0] idx);
        return (idx >= WALK_FRAMES) ? 2'd1 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/anim_step_counter.sv
// Walk-cycle timing: frame counter plus 1-based walk image index.
// Ports:
//   clk, srst    : clock, synchronous active-high reset
//   i_en         : an update happens this cycle
//   i_clear      : on an update, restart the cycle (frame_cnt 0, walk_idx 1)
//   o_idx_next   : walk index that will be held after this cycle
//   o_step_tick  : registered one-cycle pulse when the walk image advanced
module anim_step_counter
    import fw_sprite_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_en,
    input  logic       i_clear,
    output logic [1:0] o_idx_next,
    output logic       o_step_tick
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

    logic [7:0] r_frame_cnt;
    logic [7:0] w_cnt_next;
    logic [1:0] r_walk_idx;
    logic [1:0] w_idx_next;
    logic       r_step_tick;
    logic       w_tick_next;

    always_comb begin
        w_cnt_next  = r_frame_cnt;
        w_idx_next  = r_walk_idx;
        w_tick_next = 1'b0;
        if (i_en) begin
            if (i_clear) begin
                w_cnt_next = 8'd0;
                w_idx_next = 2'd1;
            end else if (r_frame_cnt == LAST_FRAME) begin
                w_cnt_next  = 8'd0;
                w_idx_next  = next_walk_idx(r_walk_idx);
                w_tick_next = 1'b1;
            end else begin
                w_cnt_next = r_frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_frame_cnt <= 8'd0;
            r_walk_idx  <= 2'd1;
            r_step_tick <= 1'b0;
        end else begin
            r_frame_cnt <= w_cnt_next;
            r_walk_idx  <= w_idx_next;
            r_step_tick <= w_tick_next;
        end
    end

    assign o_idx_next  = w_idx_next;
    assign o_step_tick = r_step_tick;

endmodule

// File: rtl/fireboy_anim_ctrl.sv
// Fireboy sprite animation sequencer. Samples movement inputs once per
// frame (frame_start with freeze low), runs the motion FSM and walk
// counter, and registers the sprite-select code so it only changes at
// frame boundaries.
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   frame_start  : one-cycle pulse at vertical blank
//   move_left/right, airborne : level inputs sampled on updates
//   freeze       : suppresses the frame_start pulse it coincides with
//   sprite_sel   : sprite_sel_t code for the ROM/palette mux
//   facing_left  : last horizontal direction (1 = left)
//   step_tick    : one-cycle pulse when the walk image advances
module fireboy_anim_ctrl
    import fw_sprite_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       airborne,
    input  logic       freeze,
    output logic [3:0] sprite_sel,
    output logic       facing_left,
    output logic       step_tick
);

    motion_t     r_state;
    motion_t     w_state_next;
    logic        r_facing;
    logic        w_facing_next;
    sprite_sel_t r_sprite_sel;
    sprite_sel_t w_sel_next;
    logic        w_update;
    logic        w_dir_l;
    logic        w_dir_r;
    logic        w_clear;
    logic [1:0]  w_idx_next;

    assign w_update = frame_start & ~freeze;
    // Both keys held decodes as no direction.
    assign w_dir_l  = move_left & ~move_right;
    assign w_dir_r  = move_right & ~move_left;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_facing     <= 1'b0;
            r_sprite_sel <= SPR_IDLE;
        end else if (w_update) begin
            r_state      <= w_state_next;
            r_facing     <= w_facing_next;
            r_sprite_sel <= w_sel_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_facing_next = r_facing;
        if (w_update) begin
            if (w_dir_l) begin
                w_facing_next = 1'b1;
            end else if (w_dir_r) begin
                w_facing_next = 1'b0;
            end
            if (airborne) begin
                w_state_next = AIR;
            end else if (w_dir_l) begin
                w_state_next = WALK_L;
            end else if (w_dir_r) begin
                w_state_next = WALK_R;
            end else begin
                w_state_next = IDLE;
            end
        end
    end

    // The walk cycle only keeps running while we stay in the same walk state.
    assign w_clear = !((w_state_next == r_state) &&
                       ((r_state == WALK_L) || (r_state == WALK_R)));

    anim_step_counter #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_step_cnt (
        .clk        (Clk),
        .srst       (Reset),
        .i_en       (w_update),
        .i_clear    (w_clear),
        .o_idx_next (w_idx_next),
        .o_step_tick(step_tick)
    );

    // Encode from next-state values so the registered code reflects this update.
    always_comb begin
        w_sel_next = SPR_IDLE;
        case (w_state_next)
            IDLE:    w_sel_next = SPR_IDLE;
            WALK_L:  w_sel_next = sprite_sel_t'({2'b00, w_idx_next});
            WALK_R:  w_sel_next = sprite_sel_t'({2'b00, w_idx_next} + 4'd3);
            AIR:     w_sel_next = w_facing_next ? SPR_JUMP_L : SPR_JUMP_R;
            default: w_sel_next = SPR_IDLE;
        endcase
    end

    assign sprite_sel  = r_sprite_sel;
    assign facing_left = r_facing;

endmodule

// File: tb/tb_fireboy_anim_ctrl.sv
module tb_fireboy_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, frame_start, move_left, move_right, airborne, freeze;
    logic [3:0] sel_a, sel_b;
    logic       face_a, face_b, tick_a, tick_b;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 Clk = ~Clk;

    // Instance A: two frames per walk image; instance B: one frame per image.
    fireboy_anim_ctrl #(.FRAMES_PER_STEP(2)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .move_left(move_left), .move_right(move_right),
        .airborne(airborne), .freeze(freeze),
        .sprite_sel(sel_a), .facing_left(face_a), .step_tick(tick_a)
    );

    fireboy_anim_ctrl #(.FRAMES_PER_STEP(1)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .move_left(move_left), .move_right(move_right),
        .airborne(airborne), .freeze(freeze),
        .sprite_sel(sel_b), .facing_left(face_b), .step_tick(tick_b)
    );

    // Behavioural reference: mode 0 idle, 1 walking left, 2 walking right, 3 in air.
    int m_fps[2] = '{2, 1};
    int m_mode[2], m_cnt[2], m_idx[2], m_sel[2];
    bit m_face[2], m_tick[2];

    function automatic void model_step(bit rst, bit fs, bit l, bit r, bit a, bit fz);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = 0; m_cnt[k] = 0; m_idx[k] = 1;
                m_face[k] = 0; m_tick[k] = 0; m_sel[k] = 0;
            end else if (fs && !fz) begin
                int dir;   // 0 none, 1 left, 2 right
                int nm;
                dir = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
                if (dir == 1) m_face[k] = 1;
                if (dir == 2) m_face[k] = 0;
                nm = a ? 3 : dir;
                m_tick[k] = 0;
                if (nm == m_mode[k] && (nm == 1 || nm == 2)) begin
                    if (m_cnt[k] == m_fps[k] - 1) begin
                        m_cnt[k]  = 0;
                        m_idx[k]  = (m_idx[k] % 3) + 1;
                        m_tick[k] = 1;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else begin
                    m_cnt[k] = 0;
                    m_idx[k] = 1;
                end
                m_mode[k] = nm;
                case (nm)
                    0:       m_sel[k] = 0;
                    1:       m_sel[k] = m_idx[k];
                    2:       m_sel[k] = 3 + m_idx[k];
                    default: m_sel[k] = m_face[k] ? 7 : 8;
                endcase
            end else begin
                m_tick[k] = 0;
            end
        end
    endfunction

    task automatic check(input string name, input int k, input int esel,
                         input bit eface, input bit etick);
        int  asel;
        bit  aface, atick;
        asel  = (k == 0) ? int'(sel_a) : int'(sel_b);
        aface = (k == 0) ? face_a : face_b;
        atick = (k == 0) ? tick_a : tick_b;
        n_vec++;
        if (asel != esel || aface != eface || atick != etick) begin
            n_miss++;
            $display("FAIL %s inst%0d t=%0t: got sel=%0d face=%0b tick=%0b, want sel=%0d face=%0b tick=%0b",
                     name, k, $time, asel, aface, atick, esel, eface, etick);
        end
    endtask

    // Drive one cycle's inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit rst, input bit fs, input bit l, input bit r,
                        input bit a, input bit fz);
        Reset = rst; frame_start = fs; move_left = l; move_right = r;
        airborne = a; freeze = fz;
        model_step(rst, fs, l, r, a, fz);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        frame_start = 1'b0;
    endtask

    typedef struct {
        bit rst, fs, l, r, a, fz;
        int sel;
        bit face, tick;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit fs, bit l, bit r, bit a, bit fz,
                                int sel, bit face, bit tick);
        vec_t v;
        v.rst = rst; v.fs = fs; v.l = l; v.r = r; v.a = a; v.fz = fz;
        v.sel = sel; v.face = face; v.tick = tick;
        vecs.push_back(v);
    endfunction

    initial begin
        bit l, r;
        Reset = 1'b1; frame_start = 0; move_left = 0; move_right = 0;
        airborne = 0; freeze = 0;
        @(posedge Clk);
        #1;

        // Expected values for the FRAMES_PER_STEP=2 instance.
        //   rst fs l r a fz   sel face tick
        add(1, 0, 0, 0, 0, 0,  0, 0, 0);               // reset state
        add(0, 1, 0, 0, 0, 0,  0, 0, 0);               // no keys x3
        add(0, 1, 0, 0, 0, 0,  0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 1, 0, 0, 0,  0, 0, 0);               // key without frame_start
        add(0, 1, 1, 0, 0, 0,  1, 1, 0);               // walk left x7
        add(0, 1, 1, 0, 0, 0,  1, 1, 0);
        add(0, 1, 1, 0, 0, 0,  2, 1, 1);
        add(0, 1, 1, 0, 0, 0,  2, 1, 0);
        add(0, 1, 1, 0, 0, 0,  3, 1, 1);
        add(0, 1, 1, 0, 0, 0,  3, 1, 0);
        add(0, 1, 1, 0, 0, 0,  1, 1, 1);               // wrap 3 -> 1
        add(0, 0, 1, 0, 0, 0,  1, 1, 0);               // tick lasts one cycle
        add(0, 1, 0, 1, 0, 0,  4, 0, 0);               // walk right x3
        add(0, 1, 0, 1, 0, 0,  4, 0, 0);
        add(0, 1, 0, 1, 0, 0,  5, 0, 1);
        add(0, 1, 1, 1, 0, 0,  0, 0, 0);               // both keys -> idle
        add(0, 1, 1, 0, 0, 0,  1, 1, 0);               // walk left, then jump right
        add(0, 1, 1, 0, 0, 0,  1, 1, 0);
        add(0, 1, 0, 1, 1, 0,  8, 0, 0);
        add(0, 1, 0, 0, 1, 0,  8, 0, 0);               // air, facing holds
        add(0, 1, 1, 0, 1, 0,  7, 1, 0);               // air turns left
        add(0, 1, 0, 0, 0, 0,  0, 1, 0);               // land, no keys
        add(0, 1, 0, 1, 0, 0,  4, 0, 0);               // walk right to sel 5
        add(0, 1, 0, 1, 0, 0,  4, 0, 0);
        add(0, 1, 0, 1, 0, 0,  5, 0, 1);
        add(0, 1, 0, 1, 0, 0,  5, 0, 0);
        add(0, 1, 0, 1, 0, 1,  5, 0, 0);               // freeze x5
        add(0, 1, 1, 0, 0, 1,  5, 0, 0);
        add(0, 1, 1, 0, 1, 1,  5, 0, 0);
        add(0, 1, 0, 0, 0, 1,  5, 0, 0);
        add(0, 1, 0, 1, 0, 1,  5, 0, 0);
        add(0, 1, 0, 1, 0, 0,  6, 0, 1);               // resumes from held count
        add(0, 1, 0, 1, 0, 0,  6, 0, 0);
        add(1, 1, 0, 1, 0, 0,  0, 0, 0);               // reset wins over frame_start
        add(0, 1, 0, 1, 0, 0,  4, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].fs, vecs[i].l, vecs[i].r, vecs[i].a, vecs[i].fz);
            check($sformatf("vec%0d", i), 0, vecs[i].sel, vecs[i].face, vecs[i].tick);
            check($sformatf("vec%0d_model", i), 1, m_sel[1], m_face[1], m_tick[1]);
        end

        // FRAMES_PER_STEP=1: advance on every update after the first in a walk state.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0); check("fps1_u1", 1, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0); check("fps1_u2", 1, 2, 1, 1);
        step(0, 1, 1, 0, 0, 0); check("fps1_u3", 1, 3, 1, 1);
        step(0, 1, 1, 0, 0, 0); check("fps1_u4", 1, 1, 1, 1);
        step(0, 0, 1, 0, 0, 0); check("fps1_gap", 1, 1, 1, 0);

        // Randomized run against the reference model, keys held with persistence.
        l = 0; r = 0;
        for (int i = 0; i < 3000; i++) begin
            bit fs, a, fz, rst;
            if ($urandom_range(7) == 0) l = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) r = 1'($urandom_range(1));
            fs  = ($urandom_range(2) != 0);
            a   = ($urandom_range(9) == 0);
            fz  = ($urandom_range(9) == 0);
            rst = ($urandom_range(199) == 0);
            step(rst, fs, l, r, a, fz);
            check("rand", 0, m_sel[0], m_face[0], m_tick[0]);
            check("rand", 1, m_sel[1], m_face[1], m_tick[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
